// File: rtl/arf_stim_pkg.sv
// Shared definitions for the ARF stimulus generator: FSM states, vector
// geometry, LFSR feedback taps and the word-index to operand-port mapping.
package arf_stim_pkg;

  // Run-control states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Operands produced per vector and the width of the fill counter.
  localparam int N_WORDS  = 10;
  localparam int WORD_K_W = 4;

  // Feedback taps of the 64-bit Fibonacci LFSR.
  localparam int TAP_0 = 63;
  localparam int TAP_1 = 62;
  localparam int TAP_2 = 60;
  localparam int TAP_3 = 59;

  // Position of each ARF operand within the fill order.
  localparam int IDX_IN_1_0  = 0;
  localparam int IDX_IN_2_0  = 1;
  localparam int IDX_IN_3_0  = 2;
  localparam int IDX_IN_4_0  = 3;
  localparam int IDX_IN_5_0  = 4;
  localparam int IDX_IN_6_0  = 5;
  localparam int IDX_IN_7_0  = 6;
  localparam int IDX_IN_8_0  = 7;
  localparam int IDX_IN_13_1 = 8;
  localparam int IDX_IN_14_1 = 9;

  // One LFSR advance: shift left, feedback into bit 0.
  function automatic logic [63:0] lfsr_next(input logic [63:0] l);
    return {l[62:0], l[TAP_0] ^ l[TAP_1] ^ l[TAP_2] ^ l[TAP_3]};
  endfunction

endpackage

// File: rtl/arf_lfsr64.sv
// 64-bit LFSR with seed load and an all-zero lockup guard on the loaded seed.
module arf_lfsr64
  import arf_stim_pkg::*;
#(
  parameter logic [63:0] SEED = 64'h0000_0000_0000_0022
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [63:0] seed,
  input  logic        step,
  output logic [63:0] state
);

  // Load takes priority over step; a zero seed falls back to SEED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (load) begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // flop samples pre-edge values regardless of statement order.
      state <= (seed == 64'd0) ? SEED : seed;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/arf_stim_gen.sv
// ARF stimulus generator: fills ten pseudo-random operands from a 64-bit
// LFSR, presents them with valid/ready, and repeats for test_size vectors.
// Build option: define ARF_STIM_SIGNED_EN to sign-extend each word from bit
// INPUT_W-1; otherwise words are zero-extended.
module arf_stim_gen
  import arf_stim_pkg::*;
#(
  parameter int          DATA_W  = 32,
  parameter int          INPUT_W = 16,
  parameter int          CNT_W   = 32,
  parameter logic [63:0] SEED    = 64'h0000_0000_0000_0022
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  test_size,
  input  logic              seed_load,
  input  logic [63:0]       seed,
  output logic              vec_valid,
  input  logic              vec_ready,
  output logic [DATA_W-1:0] in_1_0,
  output logic [DATA_W-1:0] in_2_0,
  output logic [DATA_W-1:0] in_3_0,
  output logic [DATA_W-1:0] in_4_0,
  output logic [DATA_W-1:0] in_5_0,
  output logic [DATA_W-1:0] in_6_0,
  output logic [DATA_W-1:0] in_7_0,
  output logic [DATA_W-1:0] in_8_0,
  output logic [DATA_W-1:0] in_13_1,
  output logic [DATA_W-1:0] in_14_1,
  output logic [CNT_W-1:0]  vec_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [WORD_K_W-1:0] LAST_K = WORD_K_W'(N_WORDS - 1);

  state_t                state;
  logic [WORD_K_W-1:0]   word_k;
  logic [CNT_W-1:0]      size_q;
  logic [CNT_W-1:0]      idx_inc;
  logic [DATA_W-1:0]     ops [N_WORDS];

  logic                  idle_or_done;
  logic                  lfsr_load;
  logic                  lfsr_step_en;
  logic [63:0]           lfsr_q;
  logic [63:0]           lfsr_nxt;
  logic [INPUT_W-1:0]    word_raw;
  logic [DATA_W-1:0]     word_ext;

  // Seed loading is honoured only while not in a run; stepping only in FILL.
  assign idle_or_done = (state == IDLE) || (state == DONE);
  assign lfsr_load    = idle_or_done & seed_load;
  assign lfsr_step_en = (state == FILL);

  arf_lfsr64 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (seed),
    .step  (lfsr_step_en),
    .state (lfsr_q)
  );

  // The operand word is taken from the post-step LFSR value, top INPUT_W bits.
  assign lfsr_nxt = lfsr_next(lfsr_q);
  assign word_raw = INPUT_W'(lfsr_nxt >> (64 - INPUT_W));
  assign idx_inc  = vec_idx + CNT_W'(1);

  // Widen the raw word to the operand port width.
  always_comb begin
`ifdef ARF_STIM_SIGNED_EN
    word_ext = DATA_W'($signed(word_raw));
`else
    word_ext = DATA_W'(word_raw);
`endif
  end

  // Run-control FSM with registered handshake, status and operand outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word_k    <= '0;
      size_q    <= '0;
      vec_idx   <= '0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      // NOTE: the operand array is a handful of output registers, not a RAM,
      // so it is reset here to give defined zero outputs out of reset.
      for (int i = 0; i < N_WORDS; i++) begin
        ops[i] <= '0;
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            size_q  <= test_size;
            vec_idx <= '0;
            word_k  <= '0;
            if (test_size == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= FILL;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        FILL: begin
          ops[word_k] <= word_ext;
          if (word_k == LAST_K) begin
            word_k    <= '0;
            state     <= PRESENT;
            vec_valid <= 1'b1;
          end else begin
            word_k <= word_k + WORD_K_W'(1);
          end
        end
        PRESENT: begin
          if (vec_ready) begin
            vec_valid <= 1'b0;
            vec_idx   <= idx_inc;
            if (idx_inc == size_q) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= FILL;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_1_0  = ops[IDX_IN_1_0];
  assign in_2_0  = ops[IDX_IN_2_0];
  assign in_3_0  = ops[IDX_IN_3_0];
  assign in_4_0  = ops[IDX_IN_4_0];
  assign in_5_0  = ops[IDX_IN_5_0];
  assign in_6_0  = ops[IDX_IN_6_0];
  assign in_7_0  = ops[IDX_IN_7_0];
  assign in_8_0  = ops[IDX_IN_8_0];
  assign in_13_1 = ops[IDX_IN_13_1];
  assign in_14_1 = ops[IDX_IN_14_1];

endmodule

// File: tb/tb_arf_stim_gen.sv
// Self-checking bench for arf_stim_gen: directed scenarios plus randomized
// runs against a behavioural model of the operand stream.
module tb_arf_stim_gen;

  localparam int          DATA_W  = 32;
  localparam int          INPUT_W = 16;
  localparam int          CNT_W   = 32;
  localparam logic [63:0] SEED    = 64'h0000_0000_0000_0022;
  localparam logic [63:0] TAPMASK = 64'hD800_0000_0000_0000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  test_size = '0;
  logic              seed_load = 1'b0;
  logic [63:0]       seed = '0;
  logic              vec_valid;
  logic              vec_ready = 1'b0;
  logic [DATA_W-1:0] in_1_0, in_2_0, in_3_0, in_4_0, in_5_0;
  logic [DATA_W-1:0] in_6_0, in_7_0, in_8_0, in_13_1, in_14_1;
  logic [CNT_W-1:0]  vec_idx;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  logic [63:0]       m_l;
  logic [DATA_W-1:0] exp_v [10];

  always #5 clk = ~clk;

  arf_stim_gen #(
    .DATA_W  (DATA_W),
    .INPUT_W (INPUT_W),
    .CNT_W   (CNT_W),
    .SEED    (SEED)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .test_size (test_size),
    .seed_load (seed_load),
    .seed      (seed),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .in_1_0    (in_1_0),
    .in_2_0    (in_2_0),
    .in_3_0    (in_3_0),
    .in_4_0    (in_4_0),
    .in_5_0    (in_5_0),
    .in_6_0    (in_6_0),
    .in_7_0    (in_7_0),
    .in_8_0    (in_8_0),
    .in_13_1   (in_13_1),
    .in_14_1   (in_14_1),
    .vec_idx   (vec_idx),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] dut_word(input int k);
    case (k)
      0: return in_1_0;
      1: return in_2_0;
      2: return in_3_0;
      3: return in_4_0;
      4: return in_5_0;
      5: return in_6_0;
      6: return in_7_0;
      7: return in_8_0;
      8: return in_13_1;
      default: return in_14_1;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] extend(input logic [15:0] w);
`ifdef ARF_STIM_SIGNED_EN
    return {{16{w[15]}}, w};
`else
    return {16'h0000, w};
`endif
  endfunction

  // Model: parity of tapped bits shifts in at the bottom; word = top 16 bits.
  task automatic gen_expected();
    for (int k = 0; k < 10; k++) begin
      m_l = (m_l << 1) | {63'd0, ^(m_l & TAPMASK)};
      exp_v[k] = extend(m_l[63:48]);
    end
  endtask

  task automatic check_vector(input string tag);
    for (int k = 0; k < 10; k++)
      check($sformatf("%s_op%0d", tag, k), dut_word(k), exp_v[k]);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!vec_valid && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_valid_timeout"}, vec_valid, 1);
  endtask

  // Drives one run and checks every presented vector against the model.
  task automatic run_vectors(input bit do_load, input logic [63:0] s,
                             input int n, input int ready_pct);
    int  waited;
    bit  got;
    seed      = s;
    seed_load = do_load;
    start     = 1'b1;
    test_size = n;
    vec_ready = 1'b0;
    if (do_load) m_l = (s == 64'd0) ? SEED : s;
    tick();
    start     = 1'b0;
    seed_load = 1'b0;
    seed      = {$urandom(), $urandom()};
    test_size = $urandom();
    if (n == 0) begin
      check("run0_done", done, 1);
      return;
    end
    check("run_busy_after_start", busy, 1);
    for (int v = 0; v < n; v++) begin
      gen_expected();
      got    = 1'b0;
      waited = 0;
      while (!got && waited < 200) begin
        vec_ready = ($urandom_range(99) < ready_pct);
        start     = $urandom_range(1);
        seed_load = $urandom_range(1);
        check("run_busy", busy, 1);
        if (vec_valid) begin
          check_vector($sformatf("run_v%0d", v));
          check("run_idx", vec_idx, v);
          if (vec_ready) got = 1'b1;
        end
        if (got && v == n - 1) begin
          start     = 1'b0;
          seed_load = 1'b0;
        end
        tick();
        waited++;
      end
      check("run_handshake_seen", got, 1);
    end
    start     = 1'b0;
    seed_load = 1'b0;
    vec_ready = 1'b0;
    check("run_end_done", done, 1);
    check("run_end_busy", busy, 0);
    check("run_end_valid", vec_valid, 0);
    check("run_end_idx", vec_idx, n);
  endtask

  initial begin : stim
    logic [15:0] known [10];
    logic [63:0] s;
    int          lat;
    int          vcount;

    known = '{16'hFFFE, 16'hFFFC, 16'hFFF8, 16'hFFF0, 16'hFFE0,
              16'hFFC0, 16'hFF80, 16'hFF00, 16'hFE00, 16'hFC00};

    // Reset values.
    #12;
    check("rst_valid", vec_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_idx", vec_idx, 0);
    check("rst_in_1_0", in_1_0, 0);
    check("rst_in_14_1", in_14_1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Known pattern with seed load and start together; latency and done.
    seed      = 64'hFFFF_0000_0000_0000;
    seed_load = 1'b1;
    start     = 1'b1;
    test_size = 1;
    vec_ready = 1'b1;
    m_l       = seed;
    tick();
    start     = 1'b0;
    seed_load = 1'b0;
    check("known_busy", busy, 1);
    lat = 1;
    while (!vec_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("known_latency", lat, 11);
    gen_expected();
    for (int k = 0; k < 10; k++)
      check($sformatf("known_op%0d", k), dut_word(k), extend(known[k]));
    check("known_idx", vec_idx, 0);
    tick();
    check("known_done", done, 1);
    check("known_valid_low", vec_valid, 0);
    check("known_busy_low", busy, 0);
    check("known_idx_after", vec_idx, 1);

    // Restart from DONE continues from the current LFSR state.
    run_vectors(1'b0, 64'd0, 2, 100);

    // Backpressure: 7 stalled cycles, then exactly one acceptance.
    s = {$urandom(), $urandom()} | 64'd1;
    seed = s; seed_load = 1'b1; start = 1'b1; test_size = 2; vec_ready = 1'b0;
    m_l = s;
    tick();
    start = 1'b0; seed_load = 1'b0; test_size = 9;
    wait_valid("bp1");
    gen_expected();
    check_vector("bp1");
    check("bp1_idx", vec_idx, 0);
    repeat (7) begin
      tick();
      check("bp_hold_valid", vec_valid, 1);
      check("bp_hold_idx", vec_idx, 0);
      check_vector("bp_hold");
    end
    vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
    check("bp_accept_valid", vec_valid, 0);
    check("bp_accept_idx", vec_idx, 1);
    check("bp_accept_busy", busy, 1);
    wait_valid("bp2");
    gen_expected();
    check_vector("bp2");
    check("bp2_idx", vec_idx, 1);
    vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
    check("bp2_done", done, 1);
    check("bp2_idx_end", vec_idx, 2);

    // test_size == 0: straight to DONE, no vector, LFSR untouched.
    start = 1'b1; test_size = 0;
    tick();
    start = 1'b0;
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_idx", vec_idx, 0);
    vcount = 0;
    repeat (15) begin
      tick();
      if (vec_valid) vcount++;
    end
    check("zero_no_valid", vcount, 0);
    run_vectors(1'b0, 64'd0, 1, 100);

    // Zero seed falls back to SEED.
    run_vectors(1'b1, 64'd0, 1, 100);

    // Run length 5 and reproducibility with the same seed.
    s = {$urandom(), $urandom()} | 64'd1;
    run_vectors(1'b1, s, 5, 100);
    run_vectors(1'b1, s, 5, 100);

    // Randomized runs with random backpressure.
    repeat (6) begin
      s = {$urandom(), $urandom()};
      run_vectors(1'b1, s, $urandom_range(1, 4), $urandom_range(30, 100));
    end

    // Asynchronous reset mid-FILL, then a run from the reset seed.
    start = 1'b1; test_size = 3;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", vec_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_idx", vec_idx, 0);
    for (int k = 0; k < 10; k++)
      check($sformatf("arst_op%0d", k), dut_word(k), 0);
    #3;
    rst_n = 1'b1;
    tick();
    m_l = SEED;
    run_vectors(1'b0, 64'd0, 1, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
